// File: rtl/drv_pkg.sv
// Shared types and drive codes for the half-bridge dead-time stage.
package drv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HI_ON = 2'd1,
        LO_ON = 2'd2,
        FAULT = 2'd3
    } drv_state_t;

    localparam logic [1:0] DRV_HI  = 2'b01;
    localparam logic [1:0] DRV_LO  = 2'b10;
    localparam logic [1:0] DRV_OFF = 2'b00;

endpackage

// File: rtl/drv_deadtime.sv
// Half-bridge dead-time inserter with overlap rejection and fault shutdown.
// Fault handling is built only when DRV_DEADTIME_FAULT_EN is defined.
module drv_deadtime
    import drv_pkg::*;
#(
    parameter int DT_BITS  = 8,
    parameter int OVL_BITS = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          drv_in,
    input  logic                en,
    input  logic [DT_BITS-1:0]  dead_ticks,
    input  logic                fault_in,
    input  logic                fault_clr,
    output logic [1:0]          drv_out,
    output logic                fault,
    output logic                ovl_pulse,
    output logic [OVL_BITS-1:0] ovl_cnt
);

    localparam logic [DT_BITS-1:0]  CNT_MAX = '1;
    localparam logic [OVL_BITS-1:0] OVL_MAX = '1;

    drv_state_t         state;
    drv_state_t         nxt;
    logic [DT_BITS-1:0] cnt;
    logic [DT_BITS-1:0] cnt_nxt;
    logic [1:0]         drv_nxt;
    logic               flt;
    logic               ovl;

`ifdef DRV_DEADTIME_FAULT_EN
    assign flt = fault_in;
`else
    logic unused_fault;
    assign unused_fault = fault_in ^ fault_clr;
    assign flt = 1'b0;
`endif

    // A fault outranks an overlap request, and FAULT ignores drv_in.
    assign ovl = (drv_in == 2'b11) && !flt && (state != FAULT);

    always_comb begin
        nxt     = state;
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
        if (flt) begin
            nxt = FAULT;
        end else begin
            unique case (state)
                IDLE: begin
                    if (!ovl && en && cnt >= dead_ticks) begin
                        if (drv_in == DRV_HI)
                            nxt = HI_ON;
                        else if (drv_in == DRV_LO)
                            nxt = LO_ON;
                    end
                end
                HI_ON: begin
                    if (drv_in != DRV_HI || !en)
                        nxt = IDLE;
                end
                LO_ON: begin
                    if (drv_in != DRV_LO || !en)
                        nxt = IDLE;
                end
`ifdef DRV_DEADTIME_FAULT_EN
                FAULT: begin
                    if (fault_clr)
                        nxt = IDLE;
                end
`endif
                default: nxt = IDLE;
            endcase
        end
        // Every entry into IDLE restarts the dead-time count.
        if (nxt == FAULT || (nxt == IDLE && state != IDLE))
            cnt_nxt = '0;
    end

    always_comb begin
        drv_nxt = DRV_OFF;
        unique case (nxt)
            HI_ON:   drv_nxt = DRV_HI;
            LO_ON:   drv_nxt = DRV_LO;
            default: drv_nxt = DRV_OFF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            drv_out   <= DRV_OFF;
            ovl_pulse <= 1'b0;
            ovl_cnt   <= '0;
        end else begin
            state     <= nxt;
            cnt       <= cnt_nxt;
            drv_out   <= drv_nxt;
            ovl_pulse <= ovl;
            if (ovl && ovl_cnt != OVL_MAX)
                ovl_cnt <= ovl_cnt + 1'b1;
        end
    end

`ifdef DRV_DEADTIME_FAULT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            fault <= 1'b0;
        else
            fault <= (nxt == FAULT);
    end
`else
    assign fault = 1'b0;
`endif

endmodule
